// File: rtl/uart_hex_formatter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_hex_formatter_if
// Brief    : Word-in / byte-out handshake bundle for the hex text formatter.
// Revision : 1.0
// ============================================================================
interface uart_hex_formatter_if #(
    parameter int WORD_BYTES = 4
) ();
    logic [WORD_BYTES*8-1:0] word_in_data;
    logic                    word_in_valid;
    logic                    word_in_ready;
    logic [7:0]              byte_out_data;
    logic                    byte_out_valid;
    logic                    byte_out_ready;
    logic                    busy;

    // master: the word producer and the UART transmitter side
    modport master (
        output word_in_data,
        output word_in_valid,
        input  word_in_ready,
        input  byte_out_data,
        input  byte_out_valid,
        output byte_out_ready,
        input  busy
    );

    modport slave (
        input  word_in_data,
        input  word_in_valid,
        output word_in_ready,
        output byte_out_data,
        output byte_out_valid,
        input  byte_out_ready,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_hex_formatter.sv
`default_nettype none
// ============================================================================
// Module   : uart_hex_formatter
// Brief    : Turns binary words into ASCII hex text (MS nibble first) plus a
//            line terminator, for direct connection to a UART transmitter.
// Revision : 1.0
// ============================================================================
module uart_hex_formatter #(
    parameter int WORD_BYTES = 4,
    parameter bit EMIT_CRLF  = 1'b1,
    parameter bit UPPERCASE  = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    uart_hex_formatter_if.slave bus
);

    localparam int c_W       = WORD_BYTES * 8;
    localparam int c_NIBBLES = 2 * WORD_BYTES;
    localparam int c_CNT_W   = (c_NIBBLES > 2) ? $clog2(c_NIBBLES) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD   = c_CNT_W'(c_NIBBLES - 1);
    localparam logic [7:0]         c_ALPHA_BASE = UPPERCASE ? 8'h41 : 8'h61;
    localparam logic [7:0]         c_TERM1_CHAR = EMIT_CRLF ? 8'h0D : 8'h20;
    localparam logic [7:0]         c_TERM2_CHAR = 8'h0A;

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_HEX   = 2'd1,
        c_TERM1 = 2'd2,
        c_TERM2 = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_W-1:0]     r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_ready;
    logic               r_busy;
    logic               w_fire;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return c_ALPHA_BASE + {4'h0, nib} - 8'd10;
    endfunction

    assign w_fire = r_valid & bus.byte_out_ready;

    // Every output is a flop, so nothing combinational reaches byte_out_* from ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.word_in_valid) begin
                        r_shift <= bus.word_in_data;
                        r_cnt   <= c_CNT_LOAD;
                        r_data  <= hex_ascii(bus.word_in_data[c_W-1 -: 4]);
                        r_valid <= 1'b1;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= c_HEX;
                    end
                end
                c_HEX: begin
                    if (w_fire) begin
                        if (r_cnt == '0) begin
                            r_data  <= c_TERM1_CHAR;
                            r_state <= c_TERM1;
                        end else begin
                            // Next character is the nibble just below the current top one.
                            r_shift <= r_shift << 4;
                            r_cnt   <= r_cnt - c_CNT_W'(1);
                            r_data  <= hex_ascii(r_shift[c_W-5 -: 4]);
                        end
                    end
                end
                c_TERM1: begin
                    if (w_fire) begin
                        if (EMIT_CRLF) begin
                            r_data  <= c_TERM2_CHAR;
                            r_state <= c_TERM2;
                        end else begin
                            r_valid <= 1'b0;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_IDLE;
                        end
                    end
                end
                c_TERM2: begin
                    if (w_fire) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.word_in_ready  = r_ready;
    assign bus.byte_out_data  = r_data;
    assign bus.byte_out_valid = r_valid;
    assign bus.busy           = r_busy;

endmodule
`default_nettype wire
